// File: rtl/mem_arb_pkg.sv
// Shared types for the imem/dmem to unified-memory arbiter.
// Owner tags, request function codes and access-size encodings.
package mem_arb_pkg;

  typedef enum logic {
    OWN_IMEM = 1'b0,
    OWN_DMEM = 1'b1
  } owner_t;

  localparam logic FCN_RD = 1'b0;
  localparam logic FCN_WR = 1'b1;

  localparam logic [2:0] MT_X  = 3'd0;
  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_D  = 3'd4;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;
  localparam logic [2:0] MT_WU = 3'd7;

endpackage

// File: rtl/arb_owner_fifo.sv
// Small synchronous FIFO of owner tags.
// Caller guarantees no push when full and no pop when empty.
module arb_owner_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  owner_t        push_owner_i,
  input  logic          pop_i,
  output owner_t        head_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  owner_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Next pointers and occupancy
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = wrap_inc(wr_q);
    if (pop_i)  rd_d = wrap_inc(rd_q);
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Tag storage needs no reset; count gates every read
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= push_owner_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates imem and dmem onto one memory port and routes
// in-order responses back via an owner FIFO.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int MAX_WAIT        = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_ready,
  input  logic              imem_req_valid,
  input  logic [ADDR_W-1:0] imem_req_addr,
  input  logic [DATA_W-1:0] imem_req_data,
  input  logic              imem_req_fcn,
  input  logic [2:0]        imem_req_typ,
  output logic              imem_resp_valid,
  output logic [DATA_W-1:0] imem_resp_data,
  output logic              dmem_req_ready,
  input  logic              dmem_req_valid,
  input  logic [ADDR_W-1:0] dmem_req_addr,
  input  logic [DATA_W-1:0] dmem_req_data,
  input  logic              dmem_req_fcn,
  input  logic [2:0]        dmem_req_typ,
  output logic              dmem_resp_valid,
  output logic [DATA_W-1:0] dmem_resp_data,
  input  logic              mem_req_ready,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  output logic              mem_req_fcn,
  output logic [2:0]        mem_req_typ,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              err_orphan_resp
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(MAX_WAIT + 1);

  logic          sel_i, sel_d;
  logic          starved;
  logic          not_full, can_issue;
  logic          has_out;
  logic          push, pop;
  owner_t        push_own, head;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve_q, starve_d;
  logic          err_q, err_d;

  // Grant: dmem wins unless imem has waited MAX_WAIT cycles
  always_comb begin
    starved   = (starve_q == SW'(MAX_WAIT));
    sel_i     = !rst && imem_req_valid
                && (!dmem_req_valid || starved);
    sel_d     = !rst && dmem_req_valid && !sel_i;
    not_full  = (cnt < CW'(MAX_OUTSTANDING));
    can_issue = mem_req_ready && not_full;
  end

  // Request mux toward memory; zeros when nothing granted
  always_comb begin
    mem_req_valid  = (sel_i || sel_d) && not_full;
    imem_req_ready = sel_i && can_issue;
    dmem_req_ready = sel_d && can_issue;
    mem_req_addr   = '0;
    mem_req_data   = '0;
    mem_req_fcn    = FCN_RD;
    mem_req_typ    = MT_X;
    if (sel_i) begin
      mem_req_addr = imem_req_addr;
      mem_req_data = imem_req_data;
      mem_req_fcn  = imem_req_fcn;
      mem_req_typ  = imem_req_typ;
    end else if (sel_d) begin
      mem_req_addr = dmem_req_addr;
      mem_req_data = dmem_req_data;
      mem_req_fcn  = dmem_req_fcn;
      mem_req_typ  = dmem_req_typ;
    end
  end

  // Owner bookkeeping and response steering
  always_comb begin
    push            = mem_req_valid && mem_req_ready;
    push_own        = sel_d ? OWN_DMEM : OWN_IMEM;
    has_out         = (cnt != '0);
    pop             = !rst && mem_resp_valid && has_out;
    imem_resp_valid = pop && (head == OWN_IMEM);
    dmem_resp_valid = pop && (head == OWN_DMEM);
    imem_resp_data  = mem_resp_data;
    dmem_resp_data  = mem_resp_data;
    err_d           = err_q || (mem_resp_valid && !has_out);
  end

  // Starvation counter next state, saturating at MAX_WAIT
  always_comb begin
    starve_d = starve_q;
    if (!imem_req_valid || imem_req_ready) starve_d = '0;
    else if (!starved)                     starve_d = starve_q + 1'b1;
  end

  // Arbiter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  assign err_orphan_resp = err_q;

  arb_owner_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_owner_i(push_own),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (cnt)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table,
// directed corner sequences and random traffic vs a queue model.
module tb_mem_port_arbiter;

  localparam int MO = 4;
  localparam int MW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_ready, imem_req_valid;
  logic [31:0] imem_req_addr, imem_req_data;
  logic        imem_req_fcn;
  logic [2:0]  imem_req_typ;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        dmem_req_ready, dmem_req_valid;
  logic [31:0] dmem_req_addr, dmem_req_data;
  logic        dmem_req_fcn;
  logic [2:0]  dmem_req_typ;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_data;
  logic        mem_req_ready, mem_req_valid;
  logic [31:0] mem_req_addr, mem_req_data;
  logic        mem_req_fcn;
  logic [2:0]  mem_req_typ;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        err_orphan_resp;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .MAX_OUTSTANDING(MO), .MAX_WAIT(MW)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_ready(imem_req_ready),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr),
    .imem_req_data(imem_req_data),
    .imem_req_fcn(imem_req_fcn),
    .imem_req_typ(imem_req_typ),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .dmem_req_ready(dmem_req_ready),
    .dmem_req_valid(dmem_req_valid),
    .dmem_req_addr(dmem_req_addr),
    .dmem_req_data(dmem_req_data),
    .dmem_req_fcn(dmem_req_fcn),
    .dmem_req_typ(dmem_req_typ),
    .dmem_resp_valid(dmem_resp_valid),
    .dmem_resp_data(dmem_resp_data),
    .mem_req_ready(mem_req_ready),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data),
    .mem_req_fcn(mem_req_fcn),
    .mem_req_typ(mem_req_typ),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data),
    .err_orphan_resp(err_orphan_resp)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: owners of outstanding requests,
  // how long imem has been waiting, sticky orphan flag.
  int q[$];
  int wait_m = 0;
  bit err_m  = 0;
  bit acc_i, acc_d, popped, orphan, rst_s;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    bit full, gi, gd, busy;
    logic [31:0] ea, ed;
    logic        ef;
    logic [2:0]  et;
    full = (q.size() >= MO);
    busy = (q.size() > 0);
    gi = !rst && imem_req_valid && (!dmem_req_valid || wait_m == MW);
    gd = !rst && dmem_req_valid && !gi;
    ea = gi ? imem_req_addr : gd ? dmem_req_addr : 32'h0;
    ed = gi ? imem_req_data : gd ? dmem_req_data : 32'h0;
    ef = gi ? imem_req_fcn  : gd ? dmem_req_fcn  : 1'b0;
    et = gi ? imem_req_typ  : gd ? dmem_req_typ  : 3'd0;
    acc_i  = gi && !full && mem_req_ready;
    acc_d  = gd && !full && mem_req_ready;
    popped = !rst && mem_resp_valid && busy;
    orphan = mem_resp_valid && !busy;
    rst_s  = rst;
    chk("m_mem_valid", 32'(mem_req_valid), 32'((gi || gd) && !full));
    chk("m_imem_ready", 32'(imem_req_ready), 32'(acc_i));
    chk("m_dmem_ready", 32'(dmem_req_ready), 32'(acc_d));
    chk("m_addr", mem_req_addr, ea);
    chk("m_wdata", mem_req_data, ed);
    chk("m_fcn", 32'(mem_req_fcn), 32'(ef));
    chk("m_typ", 32'(mem_req_typ), 32'(et));
    chk("m_imem_resp", 32'(imem_resp_valid), 32'(popped && q[0] == 0));
    chk("m_dmem_resp", 32'(dmem_resp_valid), 32'(popped && q[0] == 1));
    chk("m_irdata", imem_resp_data, mem_resp_data);
    chk("m_drdata", dmem_resp_data, mem_resp_data);
    chk("m_err", 32'(err_orphan_resp), 32'(err_m));
  endtask

  task automatic model_update();
    if (rst_s) begin
      q.delete();
      wait_m = 0;
      err_m  = 0;
    end else begin
      if (popped) void'(q.pop_front());
      if (acc_i) q.push_back(0);
      if (acc_d) q.push_back(1);
      if (orphan) err_m = 1;
      if (!imem_req_valid || acc_i) wait_m = 0;
      else if (wait_m < MW) wait_m++;
    end
  endtask

  task automatic settle();
    #1;
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(bit iv, bit dv, bit rdy, bit rv);
    imem_req_valid = iv;
    dmem_req_valid = dv;
    mem_req_ready  = rdy;
    mem_resp_valid = rv;
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * MO; k++) begin
      drive(0, 0, 1, q.size() > 0);
      settle();
      adv();
    end
  endtask

  typedef struct {
    bit iv, dv, rdy, rv;
    bit mv, ir, dr, irv, drv, err;
  } vec_t;

  vec_t tbl[7];

  initial begin
    rst = 1;
    drive(0, 0, 0, 0);
    imem_req_addr = 0; imem_req_data = 0;
    imem_req_fcn = 0;  imem_req_typ = 0;
    dmem_req_addr = 0; dmem_req_data = 0;
    dmem_req_fcn = 0;  dmem_req_typ = 0;
    mem_resp_data = 0;

    // iv dv rdy rv | mv ir dr irv drv err
    tbl[0] = '{0,0,1,0, 0,0,0,0,0,0};
    tbl[1] = '{1,0,1,0, 1,1,0,0,0,0};
    tbl[2] = '{0,1,1,1, 1,0,1,1,0,0};
    tbl[3] = '{1,1,0,1, 1,0,0,0,1,0};
    tbl[4] = '{0,0,1,0, 0,0,0,0,0,0};
    tbl[5] = '{0,0,1,1, 0,0,0,0,0,0};
    tbl[6] = '{0,0,0,0, 0,0,0,0,0,1};

    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      settle();
      adv();
    end
    rst = 0;

    // Vector table from the reset state
    for (int k = 0; k < 7; k++) begin
      drive(tbl[k].iv, tbl[k].dv, tbl[k].rdy, tbl[k].rv);
      mem_resp_data = 32'h100 + k;
      settle();
      chk($sformatf("t%0d_mv", k), 32'(mem_req_valid), 32'(tbl[k].mv));
      chk($sformatf("t%0d_ir", k), 32'(imem_req_ready), 32'(tbl[k].ir));
      chk($sformatf("t%0d_dr", k), 32'(dmem_req_ready), 32'(tbl[k].dr));
      chk($sformatf("t%0d_irv", k), 32'(imem_resp_valid), 32'(tbl[k].irv));
      chk($sformatf("t%0d_drv", k), 32'(dmem_resp_valid), 32'(tbl[k].drv));
      chk($sformatf("t%0d_err", k), 32'(err_orphan_resp), 32'(tbl[k].err));
      adv();
    end

    // Fill outstanding and push imem wait near saturation
    for (int k = 0; k < 7; k++) begin
      drive(1, 1, 1, 0);
      settle();
      adv();
    end
    drive(1, 1, 1, 0);
    rst = 1;
    settle();
    chk("rst_mv", 32'(mem_req_valid), 32'h0);
    chk("rst_dr", 32'(dmem_req_ready), 32'h0);
    chk("rst_ir", 32'(imem_req_ready), 32'h0);
    adv();
    rst = 0;

    // Starvation: dmem x8 then imem, then dmem again
    for (int k = 0; k < 10; k++) begin
      drive(1, 1, 1, q.size() > 0);
      settle();
      if (k == 0) begin
        chk("post_rst_err", 32'(err_orphan_resp), 32'h0);
        chk("post_rst_irv", 32'(imem_resp_valid), 32'h0);
        chk("post_rst_drv", 32'(dmem_resp_valid), 32'h0);
      end
      chk($sformatf("stv%0d_ir", k), 32'(imem_req_ready), 32'(k == 8));
      chk($sformatf("stv%0d_dr", k), 32'(dmem_req_ready), 32'(k != 8));
      adv();
    end
    drain();

    // Outstanding limit, no bypass on same-cycle pop
    for (int k = 0; k < 7; k++) begin
      drive(0, 1, 1, k == 5);
      settle();
      chk($sformatf("lim%0d_dr", k), 32'(dmem_req_ready),
          32'(k < 4 || k == 6));
      chk($sformatf("lim%0d_mv", k), 32'(mem_req_valid),
          32'(k < 4 || k == 6));
      if (k == 5) chk("lim_drv", 32'(dmem_resp_valid), 32'h1);
      adv();
    end
    drain();

    // imem-only reads with pipelined responses A,B,C
    for (int k = 0; k < 4; k++) begin
      drive(k < 3, 0, 1, k >= 1);
      imem_req_addr = 32'(4 * k);
      mem_resp_data = 32'hA + k - 1;
      settle();
      if (k < 3) chk($sformatf("io%0d_addr", k), mem_req_addr, 32'(4 * k));
      chk($sformatf("io%0d_irv", k), 32'(imem_resp_valid), 32'(k >= 1));
      chk($sformatf("io%0d_drv", k), 32'(dmem_resp_valid), 32'h0);
      if (k >= 1) chk($sformatf("io%0d_data", k), imem_resp_data, 32'hA + k - 1);
      adv();
    end
    drain();

    // Random traffic against the queue model
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 3) != 0,
            (q.size() > 0) && ($urandom_range(0, 1) == 1));
      imem_req_addr = $urandom;
      imem_req_data = $urandom;
      imem_req_fcn  = 1'($urandom);
      imem_req_typ  = 3'($urandom);
      dmem_req_addr = $urandom;
      dmem_req_data = $urandom;
      dmem_req_fcn  = 1'($urandom);
      dmem_req_typ  = 3'($urandom);
      mem_resp_data = $urandom;
      settle();
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
